// File: rtl/my7seg_scan_axil.sv
// Multiplexed 7-segment display driver with an AXI4-Lite register file.
// Scans NUM_DIGITS digits with 16-step PWM brightness per digit slot.
module my7seg_scan_axil #(
    parameter int          NUM_DIGITS         = 4,
    parameter logic [15:0] SCAN_DIV_RST       = 16'd999,
    parameter bit          ACTIVE_LOW         = 1'b1,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [6:0]                      seg,
    output logic                            dp,
    output logic [NUM_DIGITS-1:0]           an
);

    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_VALUE    = 2'd1,
        REG_MASK     = 2'd2,
        REG_PRESCALE = 2'd3
    } reg_e;

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic        en;
    logic [3:0]  bright;
    logic [31:0] value;
    logic [15:0] mask;
    logic [15:0] prescale;

    logic [15:0] pcnt;
    logic [3:0]  phase;
    logic [2:0]  digit;
    logic        tick;

    reg_e        wr_sel;
    reg_e        rd_sel;
    logic        wr_acc;
    logic        rd_acc;
    logic [31:0] wr_cur;
    logic [31:0] wr_word;

    logic        unused;
    assign unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    function automatic logic [31:0] reg_word(input reg_e sel, input logic en_f,
                                             input logic [3:0] bright_f, input logic [31:0] value_f,
                                             input logic [15:0] mask_f, input logic [15:0] pre_f);
        case (sel)
            REG_CTRL:  return {20'd0, bright_f, 7'd0, en_f};
            REG_VALUE: return value_f;
            REG_MASK:  return {16'd0, mask_f};
            default:   return {16'd0, pre_f};
        endcase
    endfunction

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    assign wr_sel = reg_e'(AWADDR[3:2]);
    assign rd_sel = reg_e'(ARADDR[3:2]);

    // NOTE: ready is combinational so it is high exactly in the accepting cycle; reset gates it off.
    assign wr_acc  = AWVALID && WVALID && !BVALID && !ARESET;
    assign rd_acc  = ARVALID && !RVALID && !ARESET;
    assign AWREADY = wr_acc;
    assign WREADY  = wr_acc;
    assign ARREADY = rd_acc;
    assign BRESP   = 2'b00;
    assign RRESP   = 2'b00;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can form.
    always_comb begin
        wr_cur  = reg_word(wr_sel, en, bright, value, mask, prescale);
        wr_word = wr_cur;
        for (int b = 0; b < 4; b++) begin
            if (WSTRB[b]) wr_word[8*b +: 8] = WDATA[8*b +: 8];
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values;
    // this is also what makes a same-cycle read return the pre-write register contents.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            BVALID <= 1'b0;
            RVALID <= 1'b0;
            RDATA  <= '0;
        end else begin
            if (wr_acc)      BVALID <= 1'b1;
            else if (BREADY) BVALID <= 1'b0;
            if (rd_acc) begin
                RVALID <= 1'b1;
                RDATA  <= reg_word(rd_sel, en, bright, value, mask, prescale);
            end else if (RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            en       <= 1'b0;
            bright   <= 4'hF;
            value    <= '0;
            mask     <= '0;
            prescale <= SCAN_DIV_RST;
        end else if (wr_acc) begin
            case (wr_sel)
                REG_CTRL: begin
                    en     <= wr_word[0];
                    bright <= wr_word[11:8];
                end
                REG_VALUE:    value    <= wr_word;
                REG_MASK:     mask     <= wr_word[15:0];
                REG_PRESCALE: prescale <= wr_word[15:0];
                default:      ;
            endcase
        end
    end

    assign tick = (pcnt == prescale);

    // A PRESCALE write restarts the prescaler but leaves phase and digit alone.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pcnt  <= '0;
            phase <= '0;
            digit <= '0;
        end else begin
            if ((wr_acc && wr_sel == REG_PRESCALE) || tick) pcnt <= '0;
            else                                           pcnt <= pcnt + 16'd1;
            if (tick) begin
                phase <= phase + 4'd1;
                if (phase == 4'hF) digit <= (digit == LAST_DIGIT) ? 3'd0 : digit + 3'd1;
            end
        end
    end

    logic [7:0]            blank_bits;
    logic [7:0]            dp_bits;
    logic                  lit;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign blank_bits = mask[15:8];
    assign dp_bits    = mask[7:0];

    always_comb begin
        lit     = en && !blank_bits[digit] && (phase <= bright);
        seg_nxt = lit ? hex_decode(value[{digit, 2'b00} +: 4]) : 7'd0;
        dp_nxt  = lit && dp_bits[digit];
        an_nxt  = lit ? (NUM_DIGITS'(1) << digit) : '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
            an  <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            seg <= seg_nxt ^ {7{ACTIVE_LOW}};
            dp  <= dp_nxt ^ ACTIVE_LOW;
            an  <= an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_my7seg_scan_axil.sv
// Self-checking bench for my7seg_scan_axil: register table, directed scan/protocol
// sequences and randomized traffic against a tick-count display model.
module tb_my7seg_scan_axil;

    localparam int ND = 4;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [6:0]  seg;
    logic        dp;
    logic [ND-1:0] an;

    my7seg_scan_axil dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers as plain words, scan position derived from a total tick count.
    logic [31:0] m_reg [4];
    int          m_pcnt;
    int          m_ticks;
    logic        m_bv;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    int          md_phase, md_dig, md_sel;
    logic        md_lit, md_tick, md_acc;

    function automatic logic [31:0] keep_mask(input int sel);
        case (sel)
            0:       return 32'h0000_0F01;
            1:       return 32'hFFFF_FFFF;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_reg[0] = 32'h0000_0F00;
            m_reg[1] = 32'h0;
            m_reg[2] = 32'h0;
            m_reg[3] = 32'd999;
            m_pcnt   = 0;
            m_ticks  = 0;
            m_bv     = 1'b0;
            e_seg    = 7'h7F;
            e_dp     = 1'b1;
            e_an     = 4'hF;
        end else begin
            md_phase = m_ticks % 16;
            md_dig   = (m_ticks / 16) % ND;
            md_lit   = m_reg[0][0] && !m_reg[2][8 + md_dig] && (md_phase <= m_reg[0][11:8]);
            e_an     = md_lit ? ~(4'b0001 << md_dig) : 4'hF;
            e_seg    = md_lit ? ~HEX[m_reg[1][4*md_dig +: 4]] : 7'h7F;
            e_dp     = md_lit ? ~m_reg[2][md_dig] : 1'b1;
            md_tick  = (m_pcnt == m_reg[3][15:0]);
            m_pcnt   = md_tick ? 0 : m_pcnt + 1;
            if (md_tick) m_ticks++;
            md_acc = AWVALID && WVALID && !m_bv;
            if (m_bv && BREADY) m_bv = 1'b0;
            if (md_acc) begin
                md_sel = int'(AWADDR[3:2]);
                for (int b = 0; b < 4; b++)
                    if (WSTRB[b]) m_reg[md_sel][8*b +: 8] = WDATA[8*b +: 8];
                m_reg[md_sel] = m_reg[md_sel] & keep_mask(md_sel);
                if (md_sel == 3) m_pcnt = 0;
                m_bv = 1'b1;
            end
        end
    end

    always @(negedge ACLK) begin
        if (chk_on && !ARESET) begin
            check("seg", 32'(seg), 32'(e_seg));
            check("an", 32'(an), 32'(e_an));
            check("dp", 32'(dp), 32'(e_dp));
            check("bvalid", 32'(BVALID), 32'(m_bv));
            check("awready", 32'(AWREADY), 32'(AWVALID && WVALID && !m_bv));
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(posedge ACLK); #1;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!(AWREADY && WREADY) && n < 50) begin @(negedge ACLK); n++; end
        check("awready_seen", 32'(AWREADY && WREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        check("bvalid_seen", 32'(BVALID), 32'd1);
        check("bresp", 32'(BRESP), 32'd0);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        @(posedge ACLK); #1;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        check("arready_seen", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
        check("rvalid_seen", 32'(RVALID), 32'd1);
        check("rresp", 32'(RRESP), 32'd0);
        data = RDATA;
        @(negedge ACLK);
        check("rdata_stable", RDATA, data);
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    function automatic int an_digit(input logic [3:0] a);
        for (int i = 0; i < ND; i++)
            if (a == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [31:0] rd, d, exp;
        logic [3:0]  ans [$];
        logic [6:0]  segs [$];
        int          runs [$];
        int          len, dg, prev, cnt_a, cnt_b, cnt_c, cnt_d, op, a;
        logic [6:0]  dig_seg [4];

        vecs[0] = '{4'h4, 4'hF, 32'h1234_5678, 32'h1234_5678};
        vecs[1] = '{4'h4, 4'h2, 32'hFFFF_FFFF, 32'h1234_FF78};
        vecs[2] = '{4'h0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0F01};
        vecs[3] = '{4'h0, 4'h1, 32'h0000_0000, 32'h0000_0F00};
        vecs[4] = '{4'h8, 4'hF, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs[5] = '{4'h8, 4'h2, 32'h0000_0000, 32'h0000_00FF};
        vecs[6] = '{4'hC, 4'hF, 32'hABCD_1234, 32'h0000_1234};
        vecs[7] = '{4'hC, 4'h1, 32'h0000_00FF, 32'h0000_12FF};
        vecs[8] = '{4'hC, 4'h0, 32'h0000_0000, 32'h0000_12FF};
        dig_seg = '{~7'h4F, ~7'h39, ~7'h6D, ~7'h77};

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        chk_on = 1'b1;

        // Reset state.
        @(negedge ACLK);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        axi_read(4'h0, rd); check("rst_ctrl", rd, 32'h0000_0F00);
        axi_read(4'h4, rd); check("rst_value", rd, 32'h0);
        axi_read(4'h8, rd); check("rst_mask", rd, 32'h0);
        axi_read(4'hC, rd); check("rst_prescale", rd, 32'h0000_03E7);

        // Register table: write then read back with byte strobes.
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Simultaneous read and write of VALUE returns the old contents.
        @(posedge ACLK); #1;
        AWADDR = 4'h4; WDATA = 32'hCAFE_0000; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h4; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
        @(negedge ACLK);
        check("simul_awready", 32'(AWREADY), 32'd1);
        check("simul_arready", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge ACLK);
        check("simul_rvalid", 32'(RVALID), 32'd1);
        check("simul_rdata_old", RDATA, 32'h1234_FF78);
        @(posedge ACLK); #1;
        RREADY = 1'b1; BREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0; BREADY = 1'b0;
        axi_read(4'h4, rd); check("simul_rdata_new", rd, 32'hCAFE_0000);

        // BREADY held low: BVALID holds and the next write waits.
        @(posedge ACLK); #1;
        AWADDR = 4'h4; WDATA = 32'h1111_1111; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge ACLK);
        check("bp_first_ready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        WDATA = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp_bvalid_hold", 32'(BVALID), 32'd1);
            check("bp_awready_low", 32'(AWREADY), 32'd0);
            check("bp_wready_low", 32'(WREADY), 32'd0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        check("bp_second_ready", 32'(AWREADY), 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        axi_read(4'h4, rd); check("bp_second_data", rd, 32'h2222_2222);

        // Scan order with full brightness.
        axi_write(4'h4, 32'h0000_A5C3, 4'hF);
        axi_write(4'hC, 32'h0, 4'hF);
        axi_write(4'h8, 32'h0, 4'hF);
        axi_write(4'h0, 32'h0000_0F01, 4'hF);
        len = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (i == 0 || an != ans[$]) begin
                if (i != 0) runs.push_back(len);
                ans.push_back(an);
                segs.push_back(seg);
                len = 1;
            end else begin
                len++;
            end
        end
        check("scan_slots", 32'(ans.size() >= 6), 32'd1);
        prev = -1;
        for (int k = 0; k < 6 && k < ans.size(); k++) begin
            dg = an_digit(ans[k]);
            check("scan_digit_valid", 32'(dg >= 0), 32'd1);
            if (dg >= 0) check($sformatf("scan_seg_d%0d", dg), 32'(segs[k]), 32'(dig_seg[dg]));
            if (k > 0) check("scan_order", dg, (prev + 1) % ND);
            if (k >= 1 && k <= 4 && k < runs.size()) check("scan_slot_len", runs[k], 32'd16);
            prev = dg;
        end

        // Brightness 3: 4 lit cycles per 16.
        axi_write(4'h0, 32'h0000_0301, 4'hF);
        cnt_a = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge ACLK);
            if (an != 4'hF) cnt_a++;
        end
        check("duty_bright3", cnt_a, 32'd16);

        // Blank digit1, decimal point on digit0.
        axi_write(4'h8, 32'h0000_0201, 4'hF);
        axi_write(4'h0, 32'h0000_0F01, 4'hF);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge ACLK);
            if (an == 4'b1101) cnt_a++;
            if (an == 4'b1110) cnt_b++;
            if (an == 4'b1110 && dp == 1'b0) cnt_c++;
            if (an != 4'b1110 && dp == 1'b0) cnt_d++;
        end
        check("blank_d1_lit", cnt_a, 32'd0);
        check("d0_lit", cnt_b, 32'd16);
        check("d0_dp_on", cnt_c, 32'd16);
        check("dp_elsewhere", cnt_d, 32'd0);

        // Disable blanks the display.
        axi_write(4'h0, 32'h0000_0F00, 4'hF);
        @(negedge ACLK);
        check("disable_blank", 32'(an), 32'hF);

        // Reset with responses pending.
        @(posedge ACLK); #1;
        AWADDR = 4'h0; WDATA = 32'h0000_0F01; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h0; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge ACLK);
        check("pend_bvalid", 32'(BVALID), 32'd1);
        check("pend_rvalid", 32'(RVALID), 32'd1);
        @(posedge ACLK); #1;
        ARESET = 1'b1; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        check("awready_in_reset", 32'(AWREADY), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        check("rst_drop_bvalid", 32'(BVALID), 32'd0);
        check("rst_drop_rvalid", 32'(RVALID), 32'd0);
        check("rst_drop_an", 32'(an), 32'hF);
        axi_read(4'h0, rd); check("rst_ctrl_again", rd, 32'h0000_0F00);

        // Randomized traffic; display and handshakes are cross-checked every cycle.
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, 3);
            if (op < 5) begin
                d = $urandom;
                if (a == 3) d[15:0] = 16'($urandom_range(0, 3));
                if (a == 0) d[0] = ($urandom_range(0, 3) != 0);
                axi_write(4'(a << 2), d, 4'($urandom_range(1, 15)));
            end else if (op < 8) begin
                exp = m_reg[a];
                axi_read(4'(a << 2), rd);
                check("rand_read", rd, exp);
            end else begin
                repeat ($urandom_range(1, 40)) @(posedge ACLK);
            end
        end

        repeat (4) @(posedge ACLK);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/my7seg_scan_axil.md
MY7SEG_SCAN_AXIL -- requirements
Module: my7seg_scan_axil

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter SCAN_DIV_RST, default 16'd999: reset value of the PRESCALE register.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1: when 1, seg/dp/an are driven inverted (low = lit/selected).
REQ-004 The block SHALL have parameters C_S_AXI_DATA_WIDTH, default 32, and C_S_AXI_ADDR_WIDTH, default 4; both are fixed at these values.
REQ-005 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have AXI4-Lite slave ports: AWADDR[3:0], AWPROT[2:0], AWVALID, AWREADY, WDATA[31:0], WSTRB[3:0], WVALID, WREADY, BRESP[1:0], BVALID, BREADY, ARADDR[3:0], ARPROT[2:0], ARVALID, ARREADY, RDATA[31:0], RRESP[1:0], RVALID, RREADY.
REQ-008 The block SHALL have port seg, output, 7 bits: segments, bit0=a through bit6=g.
REQ-009 The block SHALL have port dp, output, 1 bit: decimal point.
REQ-010 The block SHALL have port an, output, NUM_DIGITS bits: one-hot digit select.

Function
REQ-011 Registers SHALL be selected by address bits [3:2]: 0x0 CTRL (bit0 EN, bits[11:8] BRIGHT); 0x4 VALUE (nibble i = digit i); 0x8 MASK (bits[7:0] DP per digit, bits[15:8] BLANK per digit); 0xC PRESCALE (bits[15:0]). Unlisted bits SHALL read 0. Bits for digits >= NUM_DIGITS SHALL be writable but ignored.
REQ-012 A write SHALL be accepted in the cycle AWVALID and WVALID are both high and BVALID is low. AWREADY and WREADY SHALL pulse high together for exactly that cycle.
REQ-013 On write acceptance, each byte lane SHALL be updated only where WSTRB is 1. BVALID SHALL rise the next cycle with BRESP=2'b00 and SHALL hold until BREADY is high.
REQ-014 A read SHALL be accepted in the cycle ARVALID is high and RVALID is low. ARREADY SHALL pulse for that cycle. RVALID SHALL rise the next cycle with RRESP=2'b00 and registered RDATA, and SHALL hold, data stable, until RREADY.
REQ-015 Write and read channels SHALL be independent. A simultaneous read and write to the same register SHALL return the pre-write value.
REQ-016 A prescaler counter SHALL count 0..PRESCALE and then wrap to 0, emitting a one-cycle tick on wrap. PRESCALE=0 SHALL tick every cycle.
REQ-017 A 4-bit phase counter SHALL increment on each tick. When phase wraps 15->0, the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-018 Selected digit d SHALL be lit when EN=1, BLANK[d]=0 and phase <= BRIGHT, giving duty (BRIGHT+1)/16. Otherwise all of an, seg and dp SHALL be inactive.
REQ-019 Segment decode, hex to gfedcba, SHALL be: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71. dp SHALL equal DP[d].
REQ-020 seg, dp and an SHALL be registered, reflecting the counter/register state of the previous cycle (1-cycle latency).
REQ-021 Writing PRESCALE SHALL reset the prescaler counter to 0 in the same cycle; phase and digit index SHALL be unaffected.
REQ-022 Writing EN from 1 to 0 SHALL blank the outputs in the next cycle; scanning counters SHALL keep running.

Reset
REQ-023 While ARESET=1, the block SHALL hold: CTRL=0x00000F00 (EN=0, BRIGHT=15); VALUE=0; MASK=0; PRESCALE=SCAN_DIV_RST; all counters 0; digit index 0; AWREADY/WREADY/ARREADY/BVALID/RVALID=0; outputs inactive (all ones when ACTIVE_LOW=1).
REQ-024 Reset asserted mid-transaction SHALL drop any pending BVALID/RVALID with no response issued.

Verification
REQ-025 Reset, then read 0x0/0x4/0x8/0xC -> 0x00000F00, 0, 0, 0x000003E7; an=4'b1111, seg=7'h7F.
REQ-026 Write VALUE=0x0000A5C3, PRESCALE=0, CTRL=0xF01 -> each digit lit for 16 cycles; order digit0 seg=~7'h4F an=4'b1110, digit1 ~7'h39, digit2 ~7'h6D, digit3 ~7'h77; then wraps to digit0.
REQ-027 BRIGHT=3, PRESCALE=0, EN=1 -> within each 16-cycle slot, an active for exactly 4 cycles and inactive for 12.
REQ-028 Write 0x4 with WSTRB=4'b0010, WDATA=0xFFFFFFFF over VALUE=0x12345678 -> read returns 0x1234FF78.
REQ-029 Hold BREADY low 5 cycles after a write -> BVALID stays high; a second AW/W pair is not accepted until after the BREADY handshake.
REQ-030 MASK=0x00000201 -> digit1 never lit; digit0 lit with dp active.
